// File: rtl/gelato_pkg.sv
// Shared definitions for the gelato warp instruction buffer: default sizes and
// the instruction / warp-id types.
package gelato_pkg;

  localparam int GELATO_NUM_WARPS = 4;
  localparam int GELATO_DEPTH     = 4;
  localparam int GELATO_INST_W    = 64;

  function automatic int wid_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int GELATO_WID_W = wid_w(GELATO_NUM_WARPS);

  typedef logic [GELATO_INST_W-1:0] inst_t;
  typedef logic [GELATO_WID_W-1:0]  warp_id_t;

endpackage

// File: rtl/gelato_warp_ibuffer_array_if.sv
// Decoder enqueue, issue dequeue, flush and status signals of the warp
// instruction buffer; master is the pipeline side, slave is the buffer.
interface gelato_warp_ibuffer_array_if
  import gelato_pkg::*;
#(
  parameter int NUM_WARPS = GELATO_NUM_WARPS,
  parameter int INST_W    = GELATO_INST_W
);
  localparam int WID_W = wid_w(NUM_WARPS);

  logic                 dec_valid;
  logic [WID_W-1:0]     dec_warp;
  logic [INST_W-1:0]    dec_inst;
  logic                 dec_ready;
  logic                 iss_valid;
  logic [WID_W-1:0]     iss_warp;
  logic [INST_W-1:0]    iss_inst;
  logic                 iss_ready;
  logic                 flush_valid;
  logic [WID_W-1:0]     flush_warp;
  logic [NUM_WARPS-1:0] ib_nonempty;
  logic [NUM_WARPS-1:0] ib_full;

  modport master (
    output dec_valid, dec_warp, dec_inst, iss_valid, iss_warp, flush_valid, flush_warp,
    input  dec_ready, iss_inst, iss_ready, ib_nonempty, ib_full
  );

  modport slave (
    input  dec_valid, dec_warp, dec_inst, iss_valid, iss_warp, flush_valid, flush_warp,
    output dec_ready, iss_inst, iss_ready, ib_nonempty, ib_full
  );
endinterface

// File: rtl/gelato_ibuf_fifo.sv
// One warp's instruction FIFO: storage ring plus head/tail/count. Callers gate
// push/pop/clear with the global enable; clear beats push and pop.
module gelato_ibuf_fifo #(
  parameter int DEPTH  = 4,
  parameter int INST_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [INST_W-1:0] push_data,
  output logic [INST_W-1:0] head_data,
  output logic              nonempty,
  output logic              full
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [INST_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              nonempty_q, nonempty_d, full_q, full_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rst || clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Power-of-two depth lets the pointers wrap by plain overflow.
      if (push) tail_d = tail_q + 1'b1;
      if (pop)  head_d = head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
    nonempty_d = (count_d != '0);
    full_d     = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    head_q     <= head_d;
    tail_q     <= tail_d;
    count_q    <= count_d;
    nonempty_q <= nonempty_d;
    full_q     <= full_d;
  end

  always_ff @(posedge clk) begin
    if (push && !clear && !rst) mem_q[tail_q] <= push_data;
  end

  assign head_data = mem_q[head_q];
  assign nonempty  = nonempty_q;
  assign full      = full_q;
endmodule

// File: rtl/gelato_warp_ibuffer_array.sv
// Per-warp instruction buffers between decode and issue, one FIFO per warp.
// Optional same-cycle decode-to-issue bypass on an empty warp: GELATO_IBUF_BYPASS_EN.
module gelato_warp_ibuffer_array
  import gelato_pkg::*;
#(
  parameter int NUM_WARPS = GELATO_NUM_WARPS,
  parameter int DEPTH     = GELATO_DEPTH,
  parameter int INST_W    = GELATO_INST_W
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  gelato_warp_ibuffer_array_if.slave bus
);
  localparam int WID_W = wid_w(NUM_WARPS);

  logic [NUM_WARPS-1:0] nonempty, full, push, pop, clear;
  logic [INST_W-1:0]    head_data [NUM_WARPS];
  logic [WID_W-1:0]     dec_idx, iss_idx;
  logic                 dec_in, iss_in, flush_in;
  logic                 iss_base, bypass_hit, dec_fire, iss_fire;

  always_comb begin
    dec_in   = 32'(bus.dec_warp) < NUM_WARPS;
    iss_in   = 32'(bus.iss_warp) < NUM_WARPS;
    flush_in = 32'(bus.flush_warp) < NUM_WARPS;
    dec_idx  = dec_in ? bus.dec_warp : '0;
    iss_idx  = iss_in ? bus.iss_warp : '0;

    // Full is this cycle's value: a same-cycle dequeue does not open a slot.
    bus.dec_ready = rdy && !rst && dec_in && !full[dec_idx] &&
                    !(bus.flush_valid && bus.flush_warp == bus.dec_warp);
    iss_base      = rdy && !rst && iss_in &&
                    !(bus.flush_valid && bus.flush_warp == bus.iss_warp);
`ifdef GELATO_IBUF_BYPASS_EN
    bypass_hit    = bus.dec_valid && bus.dec_ready &&
                    bus.dec_warp == bus.iss_warp && !nonempty[iss_idx];
    bus.iss_ready = iss_base && (nonempty[iss_idx] || bypass_hit);
    bus.iss_inst  = nonempty[iss_idx] ? head_data[iss_idx] : bus.dec_inst;
`else
    bypass_hit    = 1'b0;
    bus.iss_ready = iss_base && nonempty[iss_idx];
    bus.iss_inst  = head_data[iss_idx];
`endif
    dec_fire = bus.dec_valid && bus.dec_ready;
    iss_fire = bus.iss_valid && bus.iss_ready;

    push  = '0;
    pop   = '0;
    clear = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      // A bypassed instruction goes straight to issue and is never stored.
      push[w]  = dec_fire && dec_idx == WID_W'(w) && !(iss_fire && bypass_hit);
      pop[w]   = iss_fire && iss_idx == WID_W'(w) && nonempty[w];
      clear[w] = rdy && bus.flush_valid && flush_in && bus.flush_warp == WID_W'(w);
    end

    bus.ib_nonempty = rst ? '0 : nonempty;
    bus.ib_full     = rst ? '0 : full;
  end

  for (genvar g = 0; g < NUM_WARPS; g++) begin : g_warp
    gelato_ibuf_fifo #(
      .DEPTH (DEPTH),
      .INST_W(INST_W)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push[g]),
      .pop      (pop[g]),
      .clear    (clear[g]),
      .push_data(bus.dec_inst),
      .head_data(head_data[g]),
      .nonempty (nonempty[g]),
      .full     (full[g])
    );
  end
endmodule

// File: tb/tb_gelato_warp_ibuffer_array.sv
// Directed table-driven bench for gelato_warp_ibuffer_array (4 warps x 4 deep).
module tb_gelato_warp_ibuffer_array;
  import gelato_pkg::*;

  typedef struct {
    bit       rs, rd, dv;
    int       dw;
    bit [7:0] di;
    bit       iv;
    int       iw;
    bit       fv;
    int       fw;
    bit       edr, eir;
    bit [7:0] eii;
    bit [3:0] ene, efu;
  } vec_t;

  logic clk = 1'b0;
  logic rst, rdy;
  int   n_checks = 0;
  int   n_pass   = 0;
  vec_t vecs[$];

  gelato_warp_ibuffer_array_if #(.NUM_WARPS(4), .INST_W(64)) bus ();

  gelato_warp_ibuffer_array #(.NUM_WARPS(4), .DEPTH(4), .INST_W(64)) dut (
    .clk(clk),
    .rst(rst),
    .rdy(rdy),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic vec_t mk(bit rs, bit rd, bit dv, int dw, bit [7:0] di, bit iv, int iw,
                              bit fv, int fw, bit edr, bit eir, bit [7:0] eii,
                              bit [3:0] ene, bit [3:0] efu);
    vec_t v;
    v.rs = rs; v.rd = rd; v.dv = dv; v.dw = dw; v.di = di; v.iv = iv; v.iw = iw;
    v.fv = fv; v.fw = fw; v.edr = edr; v.eir = eir; v.eii = eii; v.ene = ene; v.efu = efu;
    return v;
  endfunction

  task automatic drive(bit rs, bit rd, bit dv, int dw, bit [7:0] di, bit iv, int iw, bit fv, int fw);
    rst             = rs;
    rdy             = rd;
    bus.dec_valid   = dv;
    bus.dec_warp    = 2'(dw);
    bus.dec_inst    = {56'd0, di};
    bus.iss_valid   = iv;
    bus.iss_warp    = 2'(iw);
    bus.flush_valid = fv;
    bus.flush_warp  = 2'(fw);
  endtask

  initial begin
    drive(1, 1, 0, 0, 8'h00, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;

    // reset
    vecs.push_back(mk(1,1,1,0,8'h11,1,0,0,0, 0,0,8'h00, 4'b0000,4'b0000));
    // fill warp 2
    vecs.push_back(mk(0,1,1,2,8'hA0,0,3,0,0, 1,0,8'h00, 4'b0100,4'b0000));
    vecs.push_back(mk(0,1,1,2,8'hA1,0,3,0,0, 1,0,8'h00, 4'b0100,4'b0000));
    vecs.push_back(mk(0,1,1,2,8'hA2,0,3,0,0, 1,0,8'h00, 4'b0100,4'b0000));
    vecs.push_back(mk(0,1,1,2,8'hA3,0,3,0,0, 1,0,8'h00, 4'b0100,4'b0100));
    vecs.push_back(mk(0,1,1,2,8'hA4,0,2,0,0, 0,1,8'hA0, 4'b0100,4'b0100));
    vecs.push_back(mk(0,1,1,2,8'hA4,1,2,0,0, 0,1,8'hA0, 4'b0100,4'b0000));
    vecs.push_back(mk(0,1,0,0,8'h00,1,2,0,0, 1,1,8'hA1, 4'b0100,4'b0000));
    vecs.push_back(mk(0,1,0,0,8'h00,1,2,0,0, 1,1,8'hA2, 4'b0100,4'b0000));
    vecs.push_back(mk(0,1,0,0,8'h00,1,2,0,0, 1,1,8'hA3, 4'b0000,4'b0000));
    vecs.push_back(mk(0,1,0,0,8'h00,0,2,0,0, 1,0,8'h00, 4'b0000,4'b0000));
    // wrap on warp 1
    vecs.push_back(mk(0,1,1,1,8'hD0,0,3,0,0, 1,0,8'h00, 4'b0010,4'b0000));
    vecs.push_back(mk(0,1,1,1,8'hD1,0,3,0,0, 1,0,8'h00, 4'b0010,4'b0000));
    vecs.push_back(mk(0,1,1,1,8'hD2,0,3,0,0, 1,0,8'h00, 4'b0010,4'b0000));
    vecs.push_back(mk(0,1,1,1,8'hD3,1,1,0,0, 1,1,8'hD0, 4'b0010,4'b0000));
    vecs.push_back(mk(0,1,1,1,8'hD4,1,1,0,0, 1,1,8'hD1, 4'b0010,4'b0000));
    vecs.push_back(mk(0,1,1,1,8'hD5,0,3,0,0, 1,0,8'h00, 4'b0010,4'b0010));
    vecs.push_back(mk(0,1,1,1,8'hD6,1,1,0,0, 0,1,8'hD2, 4'b0010,4'b0000));
    vecs.push_back(mk(0,1,1,1,8'hD6,1,1,0,0, 1,1,8'hD3, 4'b0010,4'b0000));
    vecs.push_back(mk(0,1,1,1,8'hD7,1,1,0,0, 1,1,8'hD4, 4'b0010,4'b0000));
    vecs.push_back(mk(0,1,1,1,8'hD8,0,3,0,0, 1,0,8'h00, 4'b0010,4'b0010));
    vecs.push_back(mk(0,1,0,0,8'h00,1,1,0,0, 1,1,8'hD5, 4'b0010,4'b0000));
    vecs.push_back(mk(0,1,1,1,8'hD9,1,1,0,0, 1,1,8'hD6, 4'b0010,4'b0000));
    vecs.push_back(mk(0,1,0,0,8'h00,1,1,0,0, 1,1,8'hD7, 4'b0010,4'b0000));
    vecs.push_back(mk(0,1,0,0,8'h00,1,1,0,0, 1,1,8'hD8, 4'b0010,4'b0000));
    vecs.push_back(mk(0,1,0,0,8'h00,1,1,0,0, 1,1,8'hD9, 4'b0000,4'b0000));
    // parallel enqueue warp 0 / dequeue warp 3
    vecs.push_back(mk(0,1,1,3,8'hE0,0,0,0,0, 1,0,8'h00, 4'b1000,4'b0000));
    vecs.push_back(mk(0,1,1,3,8'hE1,0,0,0,0, 1,0,8'h00, 4'b1000,4'b0000));
    vecs.push_back(mk(0,1,1,0,8'hF0,1,3,0,0, 1,1,8'hE0, 4'b1001,4'b0000));
    vecs.push_back(mk(0,1,0,0,8'h00,1,3,0,0, 1,1,8'hE1, 4'b0001,4'b0000));
    vecs.push_back(mk(0,1,0,0,8'h00,1,0,0,0, 1,1,8'hF0, 4'b0000,4'b0000));
    // flush warp 1 with same-cycle enqueue; warp 0 untouched
    vecs.push_back(mk(0,1,1,1,8'hB0,0,3,0,0, 1,0,8'h00, 4'b0010,4'b0000));
    vecs.push_back(mk(0,1,1,1,8'hB1,0,3,0,0, 1,0,8'h00, 4'b0010,4'b0000));
    vecs.push_back(mk(0,1,1,1,8'hB2,0,3,0,0, 1,0,8'h00, 4'b0010,4'b0000));
    vecs.push_back(mk(0,1,1,0,8'hC0,0,3,0,0, 1,0,8'h00, 4'b0011,4'b0000));
    vecs.push_back(mk(0,1,1,1,8'hB5,1,1,1,1, 0,0,8'h00, 4'b0001,4'b0000));
    vecs.push_back(mk(0,1,0,0,8'h00,1,1,0,0, 1,0,8'h00, 4'b0001,4'b0000));
    vecs.push_back(mk(0,1,0,0,8'h00,1,0,0,0, 1,1,8'hC0, 4'b0000,4'b0000));
    // stall with traffic, then reset mid-burst
    vecs.push_back(mk(0,1,1,2,8'h70,0,3,0,0, 1,0,8'h00, 4'b0100,4'b0000));
    vecs.push_back(mk(0,1,1,2,8'h71,0,3,0,0, 1,0,8'h00, 4'b0100,4'b0000));
    vecs.push_back(mk(0,0,1,2,8'h72,1,2,0,0, 0,0,8'h00, 4'b0100,4'b0000));
    vecs.push_back(mk(0,0,1,2,8'h73,1,2,0,0, 0,0,8'h00, 4'b0100,4'b0000));
    vecs.push_back(mk(0,0,1,2,8'h74,1,2,0,0, 0,0,8'h00, 4'b0100,4'b0000));
    vecs.push_back(mk(0,0,0,0,8'h00,1,2,1,2, 0,0,8'h00, 4'b0100,4'b0000));
    vecs.push_back(mk(0,0,1,0,8'h75,0,0,0,0, 0,0,8'h00, 4'b0100,4'b0000));
    vecs.push_back(mk(0,1,0,0,8'h00,1,2,0,0, 1,1,8'h70, 4'b0100,4'b0000));
    vecs.push_back(mk(0,1,1,0,8'h80,0,3,0,0, 1,0,8'h00, 4'b0101,4'b0000));
    vecs.push_back(mk(1,1,1,0,8'h81,1,2,0,0, 0,0,8'h00, 4'b0000,4'b0000));
    vecs.push_back(mk(0,1,0,0,8'h00,1,2,0,0, 1,0,8'h00, 4'b0000,4'b0000));
    vecs.push_back(mk(0,1,0,0,8'h00,1,0,0,0, 1,0,8'h00, 4'b0000,4'b0000));

    foreach (vecs[i]) begin
      drive(vecs[i].rs, vecs[i].rd, vecs[i].dv, vecs[i].dw, vecs[i].di,
            vecs[i].iv, vecs[i].iw, vecs[i].fv, vecs[i].fw);
      @(negedge clk);
      chk($sformatf("v%0d dec_ready", i), 64'(bus.dec_ready), 64'(vecs[i].edr));
      chk($sformatf("v%0d iss_ready", i), 64'(bus.iss_ready), 64'(vecs[i].eir));
      if (vecs[i].eir) chk($sformatf("v%0d iss_inst", i), bus.iss_inst, {56'd0, vecs[i].eii});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d ib_nonempty", i), 64'(bus.ib_nonempty), 64'(vecs[i].ene));
      chk($sformatf("v%0d ib_full", i), 64'(bus.ib_full), 64'(vecs[i].efu));
    end

    // same-cycle enqueue and issue on empty warp 0
    drive(0, 1, 1, 0, 8'hC7, 1, 0, 0, 0);
    @(negedge clk);
    chk("byp dec_ready", 64'(bus.dec_ready), 64'd1);
`ifdef GELATO_IBUF_BYPASS_EN
    chk("byp iss_ready", 64'(bus.iss_ready), 64'd1);
    chk("byp iss_inst", bus.iss_inst, 64'hC7);
    @(posedge clk);
    #1;
    chk("byp nonempty", 64'(bus.ib_nonempty), 64'd0);
    drive(0, 1, 0, 0, 8'h00, 1, 0, 0, 0);
    @(negedge clk);
    chk("byp after iss_ready", 64'(bus.iss_ready), 64'd0);
`else
    chk("byp iss_ready", 64'(bus.iss_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("byp nonempty", 64'(bus.ib_nonempty), 64'd1);
    drive(0, 1, 0, 0, 8'h00, 1, 0, 0, 0);
    @(negedge clk);
    chk("byp next iss_ready", 64'(bus.iss_ready), 64'd1);
    chk("byp next iss_inst", bus.iss_inst, 64'hC7);
`endif
    @(posedge clk);
    #1;
    chk("byp final nonempty", 64'(bus.ib_nonempty), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
